// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic pipeline-stage register that replaces the fixed inter-stage
//   latches. It moves an opaque DATA_W-bit payload from one stage to the
//   next using a valid/ready handshake.
//   SKID=0 : one register slot. in_ready depends combinationally on out_ready.
//   SKID=1 : a main slot plus a skid slot. in_ready comes straight from a flop.
//   Empty slots always hold BUBBLE_VAL, so out_data shows the bubble whenever
//   out_valid is low.
//
// Ports
//   CLK        rising-edge clock
//   nRST       asynchronous active-low reset
//   flush      synchronous squash of every held entry
//   clr_stats  synchronous clear of stall_cnt
//   in_valid   upstream presents in_data
//   in_ready   stage can accept this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a live entry
//   out_ready  downstream consumes this cycle
//   out_data   head payload, or BUBBLE_VAL when empty
//   occupancy  number of live entries (registered)
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
module pipe_stage_reg #(
  parameter int                 DATA_W     = 64,
  parameter int                 SKID       = 0,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
  parameter int                 STALL_W    = 16
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                flush,
  input  logic                clr_stats,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          occupancy,
  output logic [STALL_W-1:0]  stall_cnt
);

  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic              main_valid, main_valid_n;
  logic              skid_valid, skid_valid_n;
  logic [DATA_W-1:0] main_data,  main_data_n;
  logic [DATA_W-1:0] skid_data,  skid_data_n;
  logic              in_ready_q;
  logic              accept, pop;

  // The skid variant keeps a dedicated in_ready flop. This flop holds the
  // inverse of the next skid_valid, so downstream ready never ripples upstream.
  assign in_ready  = (SKID != 0) ? in_ready_q : (!main_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign pop       = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (flush) begin
      // Any accept in this cycle is deliberately dropped.
      main_valid_n = 1'b0;
      main_data_n  = BUBBLE_VAL;
      skid_valid_n = 1'b0;
      skid_data_n  = BUBBLE_VAL;
    end else if (SKID == 0) begin
      if (accept) begin
        main_valid_n = 1'b1;
        main_data_n  = in_data;
      end else if (pop) begin
        main_valid_n = 1'b0;
        main_data_n  = BUBBLE_VAL;
      end
    end else begin
      if (pop && skid_valid) begin
        // in_ready is low here, so no accept can coincide with this refill.
        main_data_n  = skid_data;
        skid_valid_n = 1'b0;
        skid_data_n  = BUBBLE_VAL;
      end else if (accept) begin
        if (!main_valid || pop) begin
          main_valid_n = 1'b1;
          main_data_n  = in_data;
        end else begin
          skid_valid_n = 1'b1;
          skid_data_n  = in_data;
        end
      end else if (pop) begin
        main_valid_n = 1'b0;
        main_data_n  = BUBBLE_VAL;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      main_valid <= 1'b0;
      main_data  <= BUBBLE_VAL;
      skid_valid <= 1'b0;
      skid_data  <= BUBBLE_VAL;
      in_ready_q <= 1'b1;
      occupancy  <= 2'd0;
    end else begin
      main_valid <= main_valid_n;
      main_data  <= main_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      in_ready_q <= !skid_valid_n;
      occupancy  <= {1'b0, main_valid_n} + {1'b0, skid_valid_n};
    end
  end

  // Performance counter. Flush does not affect it, and clr_stats wins over an increment.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (clr_stats) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + STALL_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Drives one directed stimulus stream into two instances at the same time:
//   dut0 (SKID=0, STALL_W=3) and dut1 (SKID=1, STALL_W=16). Both use DATA_W=8
//   and BUBBLE_VAL=8'h20.
//   Each instance is modelled as a bounded FIFO queue with a capacity of
//   1 or 2 entries, plus an integer stall counter. Every falling edge compares
//   all outputs against that model. Literal checks at key points pin the
//   model to the expected behaviour.
module tb_pipe_stage_reg;

  localparam logic [7:0] BUB = 8'h20;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        flush, clr_stats, in_valid, out_ready;
  logic [7:0]  in_data;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [7:0]  out_data0, out_data1;
  logic [1:0]  occupancy0, occupancy1;
  logic [2:0]  stall_cnt0;
  logic [15:0] stall_cnt1;

  int check_count = 0;
  int pass_count  = 0;
  bit check_en    = 1'b0;

  // Model state. Index 0 is the single-slot stage; index 1 is the skid stage.
  logic [7:0] mq [2][$];
  int         mst [2];
  int         smax [2] = '{7, 65535};
  int         m_sz;
  bit         m_rdy, m_pop, m_acc;

  always #5 CLK = ~CLK;

  pipe_stage_reg #(.DATA_W(8), .SKID(0), .BUBBLE_VAL(8'h20), .STALL_W(3)) dut0 (
    .CLK(CLK), .nRST(nRST), .flush(flush), .clr_stats(clr_stats),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occupancy0), .stall_cnt(stall_cnt0)
  );

  pipe_stage_reg #(.DATA_W(8), .SKID(1), .BUBBLE_VAL(8'h20), .STALL_W(16)) dut1 (
    .CLK(CLK), .nRST(nRST), .flush(flush), .clr_stats(clr_stats),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occupancy1), .stall_cnt(stall_cnt1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic rdy,
                               input logic fl, input logic clr);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    clr_stats = clr;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] exp_data(input int c);
    return (mq[c].size() > 0) ? mq[c][0] : BUB;
  endfunction

  // Queue model: the stage is a FIFO of capacity 1 or 2, observed from its head.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int c = 0; c < 2; c++) begin
        mq[c].delete();
        mst[c] = 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_sz  = mq[c].size();
        m_rdy = (c == 0) ? (m_sz == 0 || out_ready) : (m_sz < 2);
        m_pop = (m_sz > 0) && out_ready;
        m_acc = in_valid && m_rdy;
        if (clr_stats) mst[c] = 0;
        else if (m_sz > 0 && !out_ready && mst[c] < smax[c]) mst[c]++;
        if (flush) mq[c].delete();
        else begin
          if (m_pop) void'(mq[c].pop_front());
          if (m_acc) mq[c].push_back(in_data);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (check_en) begin
      checkOutput("d0_out_valid", 32'(out_valid0), 32'(mq[0].size() > 0));
      checkOutput("d0_out_data",  32'(out_data0),  32'(exp_data(0)));
      checkOutput("d0_in_ready",  32'(in_ready0),  32'(mq[0].size() == 0 || out_ready));
      checkOutput("d0_occupancy", 32'(occupancy0), 32'(mq[0].size()));
      checkOutput("d0_stall_cnt", 32'(stall_cnt0), 32'(mst[0]));
      checkOutput("d1_out_valid", 32'(out_valid1), 32'(mq[1].size() > 0));
      checkOutput("d1_out_data",  32'(out_data1),  32'(exp_data(1)));
      checkOutput("d1_in_ready",  32'(in_ready1),  32'(mq[1].size() < 2));
      checkOutput("d1_occupancy", 32'(occupancy1), 32'(mq[1].size()));
      checkOutput("d1_stall_cnt", 32'(stall_cnt1), 32'(mst[1]));
    end
  end

  initial begin
    nRST = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; flush = 1'b0; clr_stats = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    nRST = 1'b1;
    check_en = 1'b1;

    $display("[TB] reset and bubble");
    checkOutput("rst_out_valid0", 32'(out_valid0), 32'd0);
    checkOutput("rst_out_data0",  32'(out_data0),  32'h20);
    checkOutput("rst_in_ready0",  32'(in_ready0),  32'd1);
    checkOutput("rst_occ0",       32'(occupancy0), 32'd0);
    checkOutput("rst_stall0",     32'(stall_cnt0), 32'd0);
    checkOutput("rst_in_ready1",  32'(in_ready1),  32'd1);
    checkOutput("rst_out_data1",  32'(out_data1),  32'h20);

    $display("[TB] streaming");
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      checkOutput("stream_data0", 32'(out_data0), 32'(i));
      checkOutput("stream_data1", 32'(out_data1), 32'(i));
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("stream_end_valid0", 32'(out_valid0), 32'd0);
    checkOutput("stream_end_data0",  32'(out_data0),  32'h20);

    $display("[TB] skid back-pressure");
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    checkOutput("skid_occ_1", 32'(occupancy1), 32'd1);
    applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
    checkOutput("skid_occ_2",   32'(occupancy1), 32'd2);
    checkOutput("skid_inrdy_0", 32'(in_ready1),  32'd0);
    applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
    checkOutput("skid_stall_3", 32'(stall_cnt1), 32'd3);
    checkOutput("skid_head_A1", 32'(out_data1),  32'hA1);
    applyStimulus(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0);
    checkOutput("skid_head_A2", 32'(out_data1),  32'hA2);
    checkOutput("skid_occ_r1",  32'(occupancy1), 32'd1);
    applyStimulus(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0);
    checkOutput("skid_head_A3", 32'(out_data1),  32'hA3);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("skid_drained", 32'(out_valid1), 32'd0);

    $display("[TB] flush with accept");
    applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_pre_occ", 32'(occupancy1), 32'd2);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_occ1",   32'(occupancy1), 32'd0);
    checkOutput("flush_valid1", 32'(out_valid1), 32'd0);
    checkOutput("flush_data1",  32'(out_data1),  32'h20);
    checkOutput("flush_valid0", 32'(out_valid0), 32'd0);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("flush_no_77", 32'(out_valid1), 32'd0);

    $display("[TB] counter saturation and clear");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    repeat (10) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_stall0", 32'(stall_cnt0), 32'd7);
    checkOutput("sat_stall1", 32'(stall_cnt1), 32'd10);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_stall0", 32'(stall_cnt0), 32'd0);
    checkOutput("clr_stall1", 32'(stall_cnt1), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    $display("[TB] async reset mid-transfer");
    applyStimulus(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hD2, 1'b0, 1'b0, 1'b0);
    checkOutput("arst_pre_occ", 32'(occupancy1), 32'd2);
    #2 nRST = 1'b0;
    #1;
    checkOutput("arst_valid1", 32'(out_valid1), 32'd0);
    checkOutput("arst_occ1",   32'(occupancy1), 32'd0);
    checkOutput("arst_data1",  32'(out_data1),  32'h20);
    checkOutput("arst_valid0", 32'(out_valid0), 32'd0);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    applyStimulus(1'b1, 8'hE1, 1'b1, 1'b0, 1'b0);
    checkOutput("arst_first1", 32'(out_data1), 32'hE1);
    checkOutput("arst_first0", 32'(out_data0), 32'hE1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("arst_end1", 32'(out_valid1), 32'd0);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register: the generic successor to the fixed inter-stage latches (IF/ID, ID/EX, EX/M, M/WB).
- Carries an opaque DATA_W-bit payload between stages with a valid/ready handshake, synchronous flush, and an optional 2-entry skid buffer.
- Empty slots present a programmable bubble value (for example the encoded RTYPE/SLL nop).
- Exports an occupancy count and a saturating back-pressure counter for performance monitoring.

Parameters:
- DATA_W, 64, payload width in bits (>=1).
- SKID, 0, 0 = single register slot; 1 = main slot plus skid slot (registered in_ready).
- BUBBLE_VAL, '0, DATA_W-bit value driven on out_data whenever out_valid=0 and loaded on reset/flush.
- STALL_W, 16, width of the stall counter.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous squash of all held entries.
- clr_stats  in  1  synchronous clear of stall_cnt.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a live entry.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  DATA_W  head payload, or BUBBLE_VAL when empty.
- occupancy  out  2  live entries (0..1 if SKID=0, 0..2 if SKID=1).
- stall_cnt  out  STALL_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset (nRST=0, async): all valid bits=0; main and skid data=BUBBLE_VAL; occupancy=0; stall_cnt=0.
  - Outputs: out_valid=0, out_data=BUBBLE_VAL, in_ready=1.
- Transfers:
  - Accept = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - Latency in_data -> out_data is exactly 1 cycle when the stage is empty or popping.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational path from out_ready).
  - On accept: main <= in_data, out_valid <= 1.
  - Pop without accept: out_valid <= 0, main <= BUBBLE_VAL.
  - Pop with accept in the same cycle: new data replaces old, out_valid stays 1.
- SKID=1:
  - in_ready = !skid_valid, driven directly from a flop with no combinational path from out_ready.
  - Accept while main empty, or while main popping with skid empty: data -> main.
  - Accept while main full and not popping: data -> skid, skid_valid <= 1.
  - Pop with skid full: skid -> main, skid_valid <= 0, skid <= BUBBLE_VAL. In this cycle in_ready=0, so no simultaneous accept.
  - Order is strictly FIFO; no entry is ever dropped or duplicated.
- Flush (synchronous):
  - Highest priority after reset.
  - Clears all valid bits and loads BUBBLE_VAL into every slot.
  - An accept in the same cycle is discarded, even though in_ready is still computed normally.
  - Pop in the flush cycle: out_valid and out_data are already visible and are consumed downstream; the stage takes no further action.
- out_data:
  - Equals main when out_valid=1.
  - Equals BUBBLE_VAL otherwise, guaranteed by the slot-clearing rules above.
- occupancy = main_valid + skid_valid, registered.
- stall_cnt:
  - Increments each cycle with out_valid & !out_ready.
  - Saturates at 2^STALL_W-1.
  - clr_stats has priority over increment and loads 0.
  - Unaffected by flush.
- Protocol assumption on upstream: in_data is held stable while in_valid & !in_ready. The stage does not check this.
- Reset mid-operation: all entries are lost immediately. No partial state survives.

Test Plan:
1. Reset and bubble. Use DATA_W=8, BUBBLE_VAL=8'h20, SKID=0. Hold nRST=0, then release -> out_valid=0, out_data=8'h20, in_ready=1, occupancy=0, stall_cnt=0.
2. Streaming. Use SKID=0 with out_ready=1. Send 8'h01..8'h05 on consecutive cycles -> each appears 1 cycle later, out_valid=1 for 5 cycles, then out_data=8'h20.
3. Skid back-pressure. Use SKID=1. Send 8'hA1, 8'hA2, 8'hA3 with out_ready=0 -> occupancy 1 then 2, in_ready=0 after 8'hA2, and 8'hA3 is held upstream.
   - Release out_ready -> outputs in order A1, A2, A3; stall_cnt=3 at release.
4. Flush with simultaneous accept. Use SKID=1 with two entries held. Assert flush and in_valid with 8'h77 in the same cycle -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE_VAL, and 8'h77 never emerges.
5. Counter saturation and clear. Use STALL_W=3, out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=7.
   - Assert clr_stats together with a stall cycle -> stall_cnt=0 next cycle.
6. Async reset mid-transfer. Use SKID=1 with occupancy=2, and drop nRST between clock edges -> out_valid=0 and occupancy=0 immediately. After release, the first accepted word is the first output.
